fpdiv_nr_param: RTL and testbench
=================================

Name: fpdiv_nr_param

Overview:
- Parametrised Newton-Raphson fixed-point divider.
- Computes num/den, or 1/den in reciprocal mode, with sign-magnitude operands: MSB is sign, Q fractional bits, N-Q-1 integer bits.
- Uses a start/ready/done handshake, a configurable iteration count, divide-by-zero detection and overflow reporting.
- Serves the encoder datapath as the shared division engine. It instantiates the team's qadd/qmult arithmetic with the same (Q,N).

Parameters:
- Q, 32, fractional bits.
- N, 48, total word width including sign.
- ITER, 6, Newton-Raphson iterations (1..15).
- CW, $clog2(N), width of the normalisation shift counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; sampled only while ready=1.
- recip  in  1  1: compute 1/den and ignore num; 0: compute num/den.
- num  in  N  dividend, sign-magnitude.
- den  in  N  divisor, sign-magnitude.
- ready  out  1  idle and able to accept start.
- quot  out  N  result, sign-magnitude; held until the next done.
- done  out  1  one-cycle pulse when quot is valid.
- div_zero  out  1  valid with done; denominator magnitude was 0.
- ovf  out  1  valid with done; result magnitude overflowed N-1 bits.

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: ready=1, done=0, quot=0, div_zero=0, ovf=0, state=IDLE, counters=0. Reset mid-operation aborts the operation, produces no done, and the block is ready on the next cycle.
- Internal constants: ONE=1.0, TWO=2.0, HALF=0.5, MAX_MAG = all ones in N-1 bits.
- IDLE: ready=1.
  - On start, capture num, den magnitudes, recip, and sign = den[N-1] ^ (recip ? 0 : num[N-1]).
  - Set d=|den|, x=ONE, k=0, dir=0, and go to NORM.
  - start while ready=0 is ignored.
- NORM: one decision per cycle.
  - If d==0: set div_zero, go to OUT.
  - Else if d>ONE: d>>=1, k++, dir=R.
  - Else if d<HALF: d<<=1, k++, dir=L.
  - Else go to MUL1 with iteration counter i=0.
  - Cycles spent in NORM = k+1, where k ≤ N-Q-1 for right shifts and k ≤ Q for left shifts.
- Iteration loop, repeated until i==ITER, then go to SCALE:
  - MUL1: p = d*x.
  - SUB: s = TWO - p, using qadd with the sign of p flipped.
  - MUL2: x = x*s; i++.
- SCALE: y = recip ? x : x*|num|.
- OUT: register quot, assert done for one cycle, return to IDLE, and drive ready=1 in the same cycle as done.
  - Magnitude = y>>k for dir=R, y<<k for dir=L.
  - Sign bit = sign, forced 0 when the magnitude is 0 (no negative zero).
  - On div_zero: magnitude = MAX_MAG, sign as computed.
- Latency: done goes high k+3*ITER+3 edges after the edge that samples start. For div_zero it is 2 edges.
- Overflow: ovf=1 if any bit would leave the N-1-bit magnitude during SCALE or the left shift.
- Accuracy: result within ±2 LSB of the exact quotient when there is no overflow and ITER ≥ 5.

Optional Feature:
- Macro FPDIV_SAT_EN.
- Defined: on ovf, the quot magnitude saturates to MAX_MAG, with the sign preserved.
- Undefined: the magnitude is the truncated low N-1 bits (wrap), and ovf is still reported.
- div_zero saturation is unconditional in both cases.

Decomposition:
- Package fpdiv_pkg:
  - State encoding: IDLE, NORM, MUL1, SUB, MUL2, SCALE, OUT.
  - Functions deriving ONE, TWO, HALF, MAX_MAG from (Q,N).
- Sub-module fpdiv_norm: registered normaliser holding d, k, dir. It exposes shift-enable and in-range/zero flags to the main FSM.
- Reuse existing qadd/qmult; no new arithmetic primitives.

Test Plan (N=48, Q=32):
- recip=1, den=4.0 (48'h0004_0000_0000) -> quot=48'h0000_4000_0000 (0.25) ±2 LSB, k=2, done 23 edges after start, ready low throughout.
- recip=0, num=6.0, den=3.0 -> quot=2.0 (48'h0002_0000_0000) ±2 LSB, div_zero=0, ovf=0.
- num=-1.0 (sign set), den=0.5 -> quot=-2.0 (48'h8002_0000_0000); then num=-0, den=-3 -> quot sign bit 0.
- num=5.0, den=0 -> done after 2 edges, div_zero=1, quot=48'h7FFF_FFFF_FFFF.
- num=16384.0, den=2^-32:
  - With FPDIV_SAT_EN: ovf=1, quot=48'h7FFF_FFFF_FFFF.
  - Without it: ovf=1, wrapped value.
- Assert rst mid-NORM and mid-MUL2 -> no done, outputs zero next cycle, ready=1; then a new start completes correctly. A start pulse while busy is ignored.

Source files
------------

// File: rtl/fpdiv_pkg.sv
// Shared definitions for the Newton-Raphson divider: FSM states, shift
// direction and fixed-point constants derived from (Q, N).
package fpdiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NORM  = 3'd1,
    S_MUL1  = 3'd2,
    S_SUB   = 3'd3,
    S_MUL2  = 3'd4,
    S_SCALE = 3'd5,
    S_OUT   = 3'd6
  } state_t;

  typedef enum logic {
    DIR_R = 1'b0,
    DIR_L = 1'b1
  } dir_t;

  localparam int unsigned FW = 128;

  function automatic logic [FW-1:0] fx_one(input int q);
    return FW'(1) << q;
  endfunction

  function automatic logic [FW-1:0] fx_two(input int q);
    return FW'(1) << (q + 1);
  endfunction

  function automatic logic [FW-1:0] fx_half(input int q);
    return FW'(1) << (q - 1);
  endfunction

  function automatic logic [FW-1:0] fx_max_mag(input int n);
    return (FW'(1) << (n - 1)) - FW'(1);
  endfunction

endpackage

// File: rtl/fpdiv_nr_param_if.sv
// Request/response bundle of the divider: start/ready/done handshake,
// operands and result flags. The requester uses master, the divider slave.
interface fpdiv_nr_param_if #(
  parameter int N = 48
);
  logic         start;
  logic         recip;
  logic [N-1:0] num;
  logic [N-1:0] den;
  logic         ready;
  logic [N-1:0] quot;
  logic         done;
  logic         div_zero;
  logic         ovf;

  modport master (
    output start, recip, num, den,
    input  ready, quot, done, div_zero, ovf
  );

  modport slave (
    input  start, recip, num, den,
    output ready, quot, done, div_zero, ovf
  );
endinterface

// File: rtl/fpdiv_norm.sv
// Divisor normaliser: brings d into [0.5, 1.0] one shift per enabled cycle,
// counting shifts in k and remembering the direction for the final rescale.
module fpdiv_norm
  import fpdiv_pkg::*;
#(
  parameter int Q  = 32,
  parameter int N  = 48,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [N-2:0]  load_mag,
  input  logic          shift_en,
  output logic [N-2:0]  d,
  output logic [CW-1:0] k,
  output dir_t          dir,
  output logic          is_zero,
  output logic          in_range
);
  localparam logic [N-2:0] ONE  = (N-1)'(fx_one(Q));
  localparam logic [N-2:0] HALF = (N-1)'(fx_half(Q));

  // Status flags consumed by the divider FSM
  always_comb begin
    is_zero  = (d == '0);
    in_range = (d >= HALF) && (d <= ONE);
  end

  // Load a fresh divisor, then halve or double it until it is in range
  always_ff @(posedge clk) begin
    if (rst) begin
      d   <= '0;
      k   <= '0;
      dir <= DIR_R;
    end else if (load) begin
      d   <= load_mag;
      k   <= '0;
      dir <= DIR_R;
    end else if (shift_en && !is_zero && !in_range) begin
      if (d > ONE) begin
        d   <= d >> 1;
        dir <= DIR_R;
      end else begin
        d   <= d << 1;
        dir <= DIR_L;
      end
      k <= k + CW'(1);
    end
  end
endmodule

// File: rtl/qadd.sv
// Sign-magnitude fixed-point adder; a zero result always carries sign 0.
module qadd #(
  parameter int N = 48
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] c
);
  logic [N-2:0] mag;
  logic         sgn;

  // Add magnitudes on equal signs, otherwise subtract the smaller one
  always_comb begin
    if (a[N-1] == b[N-1]) begin
      mag = a[N-2:0] + b[N-2:0];
      sgn = a[N-1];
    end else if (a[N-2:0] >= b[N-2:0]) begin
      mag = a[N-2:0] - b[N-2:0];
      sgn = a[N-1];
    end else begin
      mag = b[N-2:0] - a[N-2:0];
      sgn = b[N-1];
    end
    c = {(mag != '0) ? sgn : 1'b0, mag};
  end
endmodule

// File: rtl/qmult.sv
// Sign-magnitude fixed-point multiplier, truncating to Q fractional bits;
// ovr flags product bits that do not fit the N-1 bit magnitude.
module qmult #(
  parameter int Q = 32,
  parameter int N = 48
) (
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  output logic [N-1:0] o_result,
  output logic         ovr
);
  logic [2*N-3:0] prod;
  logic [2*N-3:0] scaled;

  // Full-width magnitude product, rescaled by Q
  always_comb begin
    prod     = (2*N-2)'(i_multiplicand[N-2:0]) * (2*N-2)'(i_multiplier[N-2:0]);
    scaled   = prod >> Q;
    ovr      = |scaled[2*N-3:N-1];
    o_result = {i_multiplicand[N-1] ^ i_multiplier[N-1], scaled[N-2:0]};
  end
endmodule

// File: rtl/fpdiv_nr_param.sv
// Newton-Raphson fixed-point divider (num/den or 1/den), sign-magnitude.
// FPDIV_SAT_EN: when defined, an overflowed quotient saturates to MAX_MAG;
// otherwise the low N-1 magnitude bits are kept. ovf is reported either way.
module fpdiv_nr_param
  import fpdiv_pkg::*;
#(
  parameter int Q    = 32,
  parameter int N    = 48,
  parameter int ITER = 6,
  parameter int CW   = $clog2(N)
) (
  input logic              clk,
  input logic              rst,
  fpdiv_nr_param_if.slave  bus
);
  localparam logic [N-2:0] ONE     = (N-1)'(fx_one(Q));
  localparam logic [N-2:0] TWO     = (N-1)'(fx_two(Q));
  localparam logic [N-2:0] MAX_MAG = (N-1)'(fx_max_mag(N));
  localparam logic [3:0]   ITER_L  = 4'(ITER);

  state_t         state;
  logic [N-1:0]   x_q, p_q, s_q;
  logic [N-2:0]   y_q, num_mag;
  logic [3:0]     i_q;
  logic           recip_q, sign_q, dz_q, sovf_q;

  logic [N-2:0]   d;
  logic [CW-1:0]  k;
  dir_t           dir;
  logic           n_zero, n_in_range;

  logic [N-1:0]   mul_b, mul_r, add_r;
  logic           mul_ovr;
  logic [2*N-3:0] wide;
  logic [N-2:0]   mag;
  logic           ovf_all;

  fpdiv_norm #(.Q(Q), .N(N), .CW(CW)) u_norm (
    .clk      (clk),
    .rst      (rst),
    .load     ((state == S_IDLE) && bus.start),
    .load_mag (bus.den[N-2:0]),
    .shift_en (state == S_NORM),
    .d        (d),
    .k        (k),
    .dir      (dir),
    .is_zero  (n_zero),
    .in_range (n_in_range)
  );

  // One shared multiplier: x is always one factor, the other is d, s or |num|
  always_comb begin
    mul_b = {1'b0, num_mag};
    case (state)
      S_MUL1:  mul_b = {1'b0, d};
      S_MUL2:  mul_b = s_q;
      default: ;
    endcase
  end

  qmult #(.Q(Q), .N(N)) u_mult (
    .i_multiplicand (x_q),
    .i_multiplier   (mul_b),
    .o_result       (mul_r),
    .ovr            (mul_ovr)
  );

  // TWO - p is formed by adding p with its sign flipped
  qadd #(.N(N)) u_add (
    .a (({1'b0, TWO})),
    .b ({~p_q[N-1], p_q[N-2:0]}),
    .c (add_r)
  );

  // Undo the normalisation shift and apply overflow/zero-divide policy
  always_comb begin
    wide    = (2*N-2)'(y_q) << k;
    ovf_all = !dz_q && (sovf_q || ((dir == DIR_L) && (|wide[2*N-3:N-1])));
    mag     = (dir == DIR_L) ? wide[N-2:0] : (y_q >> k);
`ifdef FPDIV_SAT_EN
    if (ovf_all) mag = MAX_MAG;
`endif
    if (dz_q) mag = MAX_MAG;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      bus.ready    <= 1'b1;
      bus.done     <= 1'b0;
      bus.quot     <= '0;
      bus.div_zero <= 1'b0;
      bus.ovf      <= 1'b0;
      x_q          <= '0;
      p_q          <= '0;
      s_q          <= '0;
      y_q          <= '0;
      num_mag      <= '0;
      i_q          <= '0;
      recip_q      <= 1'b0;
      sign_q       <= 1'b0;
      dz_q         <= 1'b0;
      sovf_q       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          bus.ready <= 1'b0;
          num_mag   <= bus.num[N-2:0];
          recip_q   <= bus.recip;
          sign_q    <= bus.den[N-1] ^ (bus.recip ? 1'b0 : bus.num[N-1]);
          x_q       <= {1'b0, ONE};
          i_q       <= '0;
          dz_q      <= 1'b0;
          sovf_q    <= 1'b0;
          state     <= S_NORM;
        end
        S_NORM: begin
          if (n_zero) begin
            dz_q  <= 1'b1;
            state <= S_OUT;
          end else if (n_in_range) begin
            i_q   <= '0;
            state <= S_MUL1;
          end
        end
        S_MUL1: begin
          p_q   <= mul_r;
          state <= S_SUB;
        end
        S_SUB: begin
          s_q   <= add_r;
          state <= S_MUL2;
        end
        S_MUL2: begin
          x_q   <= mul_r;
          i_q   <= i_q + 4'd1;
          state <= ((i_q + 4'd1) == ITER_L) ? S_SCALE : S_MUL1;
        end
        S_SCALE: begin
          y_q    <= recip_q ? x_q[N-2:0] : mul_r[N-2:0];
          sovf_q <= !recip_q && mul_ovr;
          state  <= S_OUT;
        end
        S_OUT: begin
          bus.quot     <= {(mag != '0) ? sign_q : 1'b0, mag};
          bus.div_zero <= dz_q;
          bus.ovf      <= ovf_all;
          bus.done     <= 1'b1;
          bus.ready    <= 1'b1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpdiv_nr_param.sv
// Directed bench for fpdiv_nr_param (N=48, Q=32, ITER=6). Expected results
// are pushed to a scoreboard queue at start and popped when done fires.
module tb_fpdiv_nr_param;
  localparam int N     = 48;
  localparam int Q     = 32;
  localparam int ITER  = 6;
  localparam int LIMIT = 200;

  // 16384 / 2^-32: x settles at 2-2^-32, y = 2^47-2^14 LSB, the left shift
  // by k=31 overflows and wraps to 2^47-2^45.
`ifdef FPDIV_SAT_EN
  localparam logic [N-1:0] OVF_Q = 48'h7FFF_FFFF_FFFF;
`else
  localparam logic [N-1:0] OVF_Q = 48'h6000_0000_0000;
`endif

  typedef struct {
    logic [N-1:0] q;
    int           tol;
    logic         dz;
    logic         ov;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  fpdiv_nr_param_if #(.N(N)) bus ();

  fpdiv_nr_param #(.Q(Q), .N(N), .ITER(ITER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic exp_t mk(input logic [N-1:0] q, input int tol, input logic dz,
                              input logic ov, input int lat);
    exp_t e;
    e.q = q; e.tol = tol; e.dz = dz; e.ov = ov; e.lat = lat;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_tol(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv,
                           input int tol);
    longint diff;
    logic   ok;
    diff = longint'(obs[N-2:0]) - longint'(expv[N-2:0]);
    ok = (obs[N-1] === expv[N-1]) && (diff <= longint'(tol)) && (diff >= -longint'(tol));
    n_assert++;
    assert (ok === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (+/-%0d lsb)", tag, obs, expv, tol);
    end
  endtask

  task automatic run_op(input string tag, input logic r, input logic [N-1:0] nm,
                        input logic [N-1:0] dn, input exp_t e, input bit poke);
    int   lat;
    logic rdy_bad;
    exp_t want;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b1; bus.recip = r; bus.num = nm; bus.den = dn;
    @(posedge clk); #1;
    bus.start = 1'b0;
    rdy_bad = bus.ready;
    lat = 0;
    while (lat < LIMIT) begin
      if (poke && lat == 4) begin
        bus.start = 1'b1; bus.recip = 1'b0; bus.num = 48'h0005_0000_0000; bus.den = '0;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (bus.done) break;
      if (bus.ready) rdy_bad = 1'b1;
    end
    bus.start = 1'b0;
    want = sb.pop_front();
    check({tag, " latency"}, 64'(lat), 64'(want.lat));
    check_tol({tag, " quot"}, bus.quot, want.q, want.tol);
    check({tag, " div_zero"}, 64'(bus.div_zero), 64'(want.dz));
    check({tag, " ovf"}, 64'(bus.ovf), 64'(want.ov));
    check({tag, " ready at done"}, 64'(bus.ready), 64'd1);
    check({tag, " ready busy"}, 64'(rdy_bad), 64'd0);
    @(posedge clk); #1;
    check({tag, " done pulse"}, 64'(bus.done), 64'd0);
  endtask

  task automatic no_done(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  task automatic abort_op(input string tag, input int extra);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.recip = 1'b0;
    bus.num = 48'h0006_0000_0000; bus.den = 48'h0003_0000_0000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (extra) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check({tag, " done"}, 64'(bus.done | seen), 64'd0);
    check({tag, " quot"}, 64'(bus.quot), 64'd0);
    check({tag, " ready"}, 64'(bus.ready), 64'd1);
    check({tag, " flags"}, 64'({bus.div_zero, bus.ovf}), 64'd0);
    no_done({tag, " no late done"}, 40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.recip = 1'b0; bus.num = '0; bus.den = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 64'(bus.ready), 64'd1);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset quot", 64'(bus.quot), 64'd0);
    check("reset div_zero", 64'(bus.div_zero), 64'd0);
    check("reset ovf", 64'(bus.ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("recip 1/4", 1'b1, 48'h8007_0000_0000, 48'h0004_0000_0000,
           mk(48'h0000_4000_0000, 2, 1'b0, 1'b0, 23), 1'b0);
    run_op("6/3", 1'b0, 48'h0006_0000_0000, 48'h0003_0000_0000,
           mk(48'h0002_0000_0000, 2, 1'b0, 1'b0, 23), 1'b0);
    run_op("-1/0.5", 1'b0, 48'h8001_0000_0000, 48'h0000_8000_0000,
           mk(48'h8002_0000_0000, 2, 1'b0, 1'b0, 21), 1'b0);
    run_op("-0/-3", 1'b0, 48'h8000_0000_0000, 48'h8003_0000_0000,
           mk(48'h0, 0, 1'b0, 1'b0, 23), 1'b0);
    run_op("-0/3", 1'b0, 48'h8000_0000_0000, 48'h0003_0000_0000,
           mk(48'h0, 0, 1'b0, 1'b0, 23), 1'b0);
    run_op("5/0", 1'b0, 48'h0005_0000_0000, 48'h0,
           mk(48'h7FFF_FFFF_FFFF, 0, 1'b1, 1'b0, 2), 1'b0);
    run_op("16384/lsb", 1'b0, 48'h4000_0000_0000, 48'h0000_0000_0001,
           mk(OVF_Q, 0, 1'b0, 1'b1, 52), 1'b0);
    run_op("recip 1/-8", 1'b1, 48'h8003_0000_0000, 48'h8008_0000_0000,
           mk(48'h8000_2000_0000, 2, 1'b0, 1'b0, 24), 1'b0);
    run_op("recip 1/0.75", 1'b1, 48'h0, 48'h0000_C000_0000,
           mk(48'h0001_5555_5555, 2, 1'b0, 1'b0, 21), 1'b0);
    run_op("busy start", 1'b1, 48'h0, 48'h0004_0000_0000,
           mk(48'h0000_4000_0000, 2, 1'b0, 1'b0, 23), 1'b1);
    no_done("busy start no extra done", 40);

    abort_op("rst in NORM", 0);
    abort_op("rst in MUL2", 5);

    run_op("6/3 after rst", 1'b0, 48'h0006_0000_0000, 48'h0003_0000_0000,
           mk(48'h0002_0000_0000, 2, 1'b0, 1'b0, 23), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
